// File: rtl/mem_sync_sp_requester.sv
// mem_sync_sp_requester
// Initiator side of a synchronous single-port 64-bit memory interface.
// Takes byte-addressed load/store requests from the LSU, drives the word
// address, byte write enables and lane-shifted write data toward the memory,
// then aligns and sign/zero-extends the read data into a response.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_*/o_req_ready request channel (valid/ready), byte address, size,
//                       signedness, right-aligned store data
//   o_rsp_*/i_rsp_ready response channel (valid/ready), load data, error
//   o_mem_addr/wdata/wen/i_mem_rdata  memory port (write-first, read data
//                       one cycle after address)
//
// Build option: MEM_SYNC_SP_REQ_SPLIT_EN
//   defined   - accesses crossing a word boundary are done as two beats
//   undefined - crossing accesses are rejected with o_rsp_err=1
//
// Sequence per request: ACC1 -> [ACC2] -> CAPT -> ALGN -> RESP.
// ACC1/ACC2 are the cycles in which the registered address/wen are presented
// to the memory; ALGN is the cycle whose closing edge builds the response.
module mem_sync_sp_requester #(
    parameter int DEPTH       = 2048,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int BADDR_WIDTH = ADDR_WIDTH + 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_we,
    input  logic [BADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]             i_req_size,
    input  logic                   i_req_signed,
    input  logic [63:0]            i_req_wdata,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [63:0]            o_rsp_rdata,
    output logic                   o_rsp_err,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic [63:0]            o_mem_wdata,
    output logic [7:0]             o_mem_wen,
    input  logic [63:0]            i_mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC1 = 3'd1;
    localparam logic [2:0] S_ACC2 = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_ALGN = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wen_q, mem_wen_d;
    logic [63:0]           mem_wdata_q, mem_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [63:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [2:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
`ifdef MEM_SYNC_SP_REQ_SPLIT_EN
    logic                  split_q, split_d;
    logic [7:0]            wen_hi_q, wen_hi_d;
    logic [63:0]           wdata_hi_q, wdata_hi_d;
    logic [63:0]           hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] next_word;
    logic [127:0]          raw;
`endif

    logic [3:0]   nbytes;
    logic [7:0]   size_mask;
    logic [15:0]  lane_mask;
    logic [127:0] lane_data;
    logic         crossing;
    logic [63:0]  aligned;
    logic [63:0]  extended;

    assign o_req_ready = (state_q == S_IDLE);
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wen   = mem_wen_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

    // Request decode. Mask and data are shifted into a double-width window so
    // the low half is beat 1 and the high half is whatever spills into beat 2.
    always_comb begin
        nbytes = 4'd1 << i_req_size;
        case (i_req_size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        lane_mask = {8'h00, size_mask} << i_req_addr[2:0];
        lane_data = {64'h0, i_req_wdata} << {i_req_addr[2:0], 3'b000};
        crossing  = ({1'b0, i_req_addr[2:0]} + nbytes) > 4'd8;
    end

    // Response alignment: select the requested bytes starting at the offset,
    // then sign- or zero-extend according to the access size.
    always_comb begin
`ifdef MEM_SYNC_SP_REQ_SPLIT_EN
        next_word = (mem_addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0
                                                          : mem_addr_q + ADDR_WIDTH'(1);
        raw       = split_q ? {i_mem_rdata, hold_q} : {64'h0, i_mem_rdata};
        aligned   = raw[{off_q, 3'b000} +: 64];
`else
        aligned   = i_mem_rdata >> {off_q, 3'b000};
`endif
        case (size_q)
            2'd0:    extended = sgn_q ? {{56{aligned[7]}},  aligned[7:0]}  : {56'h0, aligned[7:0]};
            2'd1:    extended = sgn_q ? {{48{aligned[15]}}, aligned[15:0]} : {48'h0, aligned[15:0]};
            2'd2:    extended = sgn_q ? {{32{aligned[31]}}, aligned[31:0]} : {32'h0, aligned[31:0]};
            default: extended = aligned;
        endcase
    end

    // Main sequencer. Every memory-side and response-side output is the
    // registered value computed here.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = mem_wen_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        off_d       = off_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        we_d        = we_q;
        err_d       = err_q;
`ifdef MEM_SYNC_SP_REQ_SPLIT_EN
        split_d     = split_q;
        wen_hi_d    = wen_hi_q;
        wdata_hi_d  = wdata_hi_q;
        hold_d      = hold_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    mem_addr_d  = i_req_addr[BADDR_WIDTH-1:3];
                    mem_wen_d   = i_req_we ? lane_mask[7:0] : 8'h00;
                    mem_wdata_d = lane_data[63:0];
                    off_d       = i_req_addr[2:0];
                    size_d      = i_req_size;
                    sgn_d       = i_req_signed;
                    we_d        = i_req_we;
`ifdef MEM_SYNC_SP_REQ_SPLIT_EN
                    split_d     = crossing;
                    err_d       = 1'b0;
                    wen_hi_d    = i_req_we ? lane_mask[15:8] : 8'h00;
                    wdata_hi_d  = lane_data[127:64];
`else
                    // Without split support a crossing access never touches memory.
                    err_d       = crossing;
                    if (crossing) begin
                        mem_wen_d = 8'h00;
                    end
`endif
                    state_d     = S_ACC1;
                end
            end
            S_ACC1: begin
`ifdef MEM_SYNC_SP_REQ_SPLIT_EN
                if (split_q) begin
                    mem_addr_d  = next_word;
                    mem_wen_d   = wen_hi_q;
                    mem_wdata_d = wdata_hi_q;
                    state_d     = S_ACC2;
                end else begin
                    mem_wen_d   = 8'h00;
                    state_d     = S_CAPT;
                end
`else
                mem_wen_d = 8'h00;
                state_d   = S_CAPT;
`endif
            end
`ifdef MEM_SYNC_SP_REQ_SPLIT_EN
            // Beat-1 read data is on i_mem_rdata during this cycle; keep it.
            S_ACC2: begin
                mem_wen_d = 8'h00;
                hold_d    = i_mem_rdata;
                state_d   = S_CAPT;
            end
`endif
            S_CAPT: begin
                mem_wen_d = 8'h00;
                state_d   = S_ALGN;
            end
            S_ALGN: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_rdata_d = (we_q || err_q) ? 64'h0 : extended;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                mem_wen_d   = 8'h00;
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wen_q   <= 8'h00;
            mem_wdata_q <= 64'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'h0;
            rsp_err_q   <= 1'b0;
            off_q       <= 3'd0;
            size_q      <= 2'd0;
            sgn_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
`ifdef MEM_SYNC_SP_REQ_SPLIT_EN
            split_q     <= 1'b0;
            wen_hi_q    <= 8'h00;
            wdata_hi_q  <= 64'h0;
            hold_q      <= 64'h0;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            we_q        <= we_d;
            err_q       <= err_d;
`ifdef MEM_SYNC_SP_REQ_SPLIT_EN
            split_q     <= split_d;
            wen_hi_q    <= wen_hi_d;
            wdata_hi_q  <= wdata_hi_d;
            hold_q      <= hold_d;
`endif
        end
    end

endmodule
